// File: rtl/cmd_rx_pkg.sv
// Shared types and command codes for the cmd_rx UART command receiver.
package cmd_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    AUTH_OFF  = 2'd0,
    AUTH_PWR1 = 2'd1,
    AUTH_PWR2 = 2'd2
  } auth_state_t;

  localparam logic [7:0] CMD_GO   = 8'h47;
  localparam logic [7:0] CMD_STOP = 8'h53;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: RX synchroniser, bit-timing FSM, byte output with one-cycle strobe.
// Stop-bit rejection is built only when CMD_RX_STOP_CHK_EN is defined.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge on the synchronised input
// RX_START | timing to mid start bit; a high level there is a glitch
// RX_DATA  | sampling 8 data bits LSB first, one per BAUD_DIV cycles
// RX_STOP  | timing to mid stop bit, then publish the byte
module uart_rx_core
  import cmd_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_rdy_o,
  output logic       frm_err_o
);

  localparam int unsigned   CW        = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] LOAD_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] LOAD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          rdy_q, rdy_d;
  logic          tc;

`ifdef CMD_RX_STOP_CHK_EN
  logic          err_q, err_d;
`endif

  // Down-counter reaching 1 marks the sample point, so a load of N spans N cycles.
  assign tc = (cnt_q == CNT_ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
`ifdef CMD_RX_STOP_CHK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          state_d = RX_START;
          cnt_d   = LOAD_HALF;
        end
      end
      RX_START: begin
        if (tc) begin
          if (!rx_s2_q) begin
            state_d = RX_DATA;
            cnt_d   = LOAD_FULL;
            bit_d   = 4'd0;
          end else begin
            state_d = RX_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RX_DATA: begin
        if (tc) begin
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 4'd1;
          cnt_d   = LOAD_FULL;
          if (bit_q == 4'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RX_STOP: begin
        if (tc) begin
          state_d = RX_IDLE;
          cnt_d   = '0;
          bit_d   = 4'd0;
`ifdef CMD_RX_STOP_CHK_EN
          if (rx_s2_q) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
`else
          data_d = shift_q;
          rdy_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= 4'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      rdy_q     <= 1'b0;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
    end
  end

`ifdef CMD_RX_STOP_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign frm_err_o = err_q;
`else
  assign frm_err_o = 1'b0;
`endif

  assign rx_data_o = data_q;
  assign rx_rdy_o  = rdy_q;

endmodule

// File: rtl/cmd_rx.sv
// UART command receiver: 'G' then 'S' sequence gates the balance-controller power-up.
// Optional stop-bit rejection in the receive core via CMD_RX_STOP_CHK_EN.
//
// state     | meaning
// AUTH_OFF  | power off, waiting for 'G'
// AUTH_PWR1 | 'G' seen, power on, waiting for 'S'
// AUTH_PWR2 | running with rider; rider_off drops power
module cmd_rx
  import cmd_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err,
  output logic       pwr_up
);

  auth_state_t auth_q, auth_d;
  logic        pwr_up_q;

  uart_rx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (RX),
    .rx_data_o (rx_data),
    .rx_rdy_o  (rx_rdy),
    .frm_err_o (frm_err)
  );

  always_comb begin
    auth_d = auth_q;
    case (auth_q)
      AUTH_OFF: begin
        if (rx_rdy && rx_data == CMD_GO) auth_d = AUTH_PWR1;
      end
      AUTH_PWR1: begin
        if (rx_rdy && rx_data == CMD_STOP) auth_d = rider_off ? AUTH_OFF : AUTH_PWR2;
      end
      AUTH_PWR2: begin
        // A fresh 'G' outranks a simultaneous rider_off.
        if (rx_rdy && rx_data == CMD_GO) auth_d = AUTH_PWR1;
        else if (rider_off)              auth_d = AUTH_OFF;
      end
      default: auth_d = AUTH_OFF;
    endcase
  end

  // pwr_up registers the next state so it moves one cycle after the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      auth_q   <= AUTH_OFF;
      pwr_up_q <= 1'b0;
    end else begin
      auth_q   <= auth_d;
      pwr_up_q <= (auth_d != AUTH_OFF);
    end
  end

  assign pwr_up = pwr_up_q;

endmodule

// File: tb/tb_cmd_rx.sv
// Self-checking bench for cmd_rx: directed scenarios plus randomized frames and rider_off,
// checked every cycle against a frame-level model of the receiver and command decoder.
module tb_cmd_rx;

  localparam int unsigned BAUD_DIV   = 40;
  localparam int          GLITCH_LEN = BAUD_DIV / 2 - 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       rider_off = 1'b0;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frm_err;
  logic       pwr_up;

  int checks = 0;
  int errors = 0;

  // Frames handed to the line: {stop bit value, byte}; the monitor consumes them in order.
  logic [8:0] sent_q[$];
  int         rd_idx = 0;
  int         drv_idx = -1;
  int         rdy_cnt = 0;
  int         err_cnt = 0;
  logic       ro_rand = 1'b0;

  logic [7:0] exp_data = 8'h00;
  int         exp_mode = 0;
  logic       exp_pwr = 1'b0;

  cmd_rx #(.BAUD_DIV(BAUD_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .rider_off (rider_off),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .frm_err   (frm_err),
    .pwr_up    (pwr_up)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Model: exp_mode 0 = power off, 1 = 'G' accepted, 2 = 'G','S' accepted with rider present.
  always @(negedge clk) begin
    logic [8:0] f;
    logic [7:0] b;
    logic       got;
    got = 1'b0;
    b   = 8'h00;
    if (rx_rdy) begin
      rdy_cnt++;
      chk("rdy_in_stop_bit", 32'(drv_idx), 32'(9));
      chk("rdy_expected", 32'(rd_idx < sent_q.size()), 32'(1));
      if (rd_idx < sent_q.size()) begin
        f = sent_q[rd_idx];
        rd_idx++;
`ifdef CMD_RX_STOP_CHK_EN
        chk("rdy_stop_good", 32'(f[8]), 32'(1));
`endif
        exp_data = f[7:0];
        b        = f[7:0];
        got      = 1'b1;
      end
    end
    if (frm_err) begin
      err_cnt++;
`ifdef CMD_RX_STOP_CHK_EN
      chk("err_in_stop_bit", 32'(drv_idx), 32'(9));
      chk("err_expected", 32'(rd_idx < sent_q.size()), 32'(1));
      if (rd_idx < sent_q.size()) begin
        f = sent_q[rd_idx];
        rd_idx++;
        chk("err_stop_bad", 32'(f[8]), 32'(0));
      end
`endif
    end
`ifndef CMD_RX_STOP_CHK_EN
    chk("frm_err_zero", 32'(frm_err), 32'(0));
`endif
    chk("rx_data", 32'(rx_data), 32'(exp_data));
    chk("pwr_up", 32'(pwr_up), 32'(exp_pwr));

    if (rst) begin
      rd_idx   = sent_q.size();
      exp_data = 8'h00;
      exp_mode = 0;
      exp_pwr  = 1'b0;
    end else begin
      case (exp_mode)
        0: if (got && b == 8'h47) exp_mode = 1;
        1: if (got && b == 8'h53) exp_mode = rider_off ? 0 : 2;
        2: begin
          if (got && b == 8'h47) exp_mode = 1;
          else if (rider_off)    exp_mode = 0;
        end
        default: exp_mode = 0;
      endcase
      exp_pwr = (exp_mode != 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (ro_rand && $urandom_range(0, 99) == 0) rider_off = ~rider_off;
    end
  endtask

  // abort_bit >= 0 pulses rst in the middle of that data bit and abandons the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len,
                            input int abort_bit);
    sent_q.push_back({stop_v, b});
    drv_idx = 0;
    RX = 1'b0;
    cyc(BAUD_DIV);
    for (int i = 0; i < 8; i++) begin
      drv_idx = i + 1;
      RX = b[i];
      if (abort_bit == i) begin
        cyc(BAUD_DIV / 2);
        rst = 1'b1;
        RX = 1'b1;
        drv_idx = -1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_rx_rdy", 32'(rx_rdy), 32'(0));
        chk("rst_frm_err", 32'(frm_err), 32'(0));
        chk("rst_pwr_up", 32'(pwr_up), 32'(0));
        cyc(1);
        return;
      end
      cyc(BAUD_DIV);
    end
    drv_idx = 9;
    RX = stop_v;
    cyc(BAUD_DIV * stop_len);
    chk("frame_consumed", 32'(rd_idx), 32'(sent_q.size()));
    RX = 1'b1;
    drv_idx = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int r0;
    int e0;
    rst = 1'b1;
    cyc(4);
    rst = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("init_rx_data", 32'(rx_data), 32'h00);
    chk("init_rx_rdy", 32'(rx_rdy), 32'(0));
    chk("init_frm_err", 32'(frm_err), 32'(0));
    chk("init_pwr_up", 32'(pwr_up), 32'(0));
    cyc(1);

    r0 = rdy_cnt;
    send_frame(8'h47, 1'b1, 1, -1);
    cyc(2);
    @(negedge clk);
    chk("go_one_rdy", 32'(rdy_cnt - r0), 32'(1));
    chk("go_rx_data", 32'(rx_data), 32'h47);
    chk("go_pwr_up", 32'(pwr_up), 32'(1));
    cyc(1);

    rider_off = 1'b0;
    send_frame(8'h53, 1'b1, 1, -1);
    cyc(2);
    @(negedge clk);
    chk("stop_rider_on_pwr", 32'(pwr_up), 32'(1));
    cyc(1);
    rider_off = 1'b1;
    cyc(1);
    rider_off = 1'b0;
    @(negedge clk);
    chk("rider_leaves_pwr", 32'(pwr_up), 32'(0));
    cyc(1);

    send_frame(8'h47, 1'b1, 1, -1);
    rider_off = 1'b1;
    send_frame(8'h53, 1'b1, 1, -1);
    cyc(2);
    @(negedge clk);
    chk("stop_rider_off_pwr", 32'(pwr_up), 32'(0));
    cyc(1);
    rider_off = 1'b0;

    r0 = rdy_cnt;
    RX = 1'b0;
    cyc(GLITCH_LEN);
    RX = 1'b1;
    cyc(2 * BAUD_DIV);
    @(negedge clk);
    chk("glitch_no_rdy", 32'(rdy_cnt - r0), 32'(0));
    cyc(1);
    send_frame(8'h47, 1'b1, 1, -1);
    cyc(2);
    @(negedge clk);
    chk("post_glitch_data", 32'(rx_data), 32'h47);
    chk("post_glitch_pwr", 32'(pwr_up), 32'(1));
    cyc(1);

    rider_off = 1'b1;
    send_frame(8'h53, 1'b1, 1, -1);
    rider_off = 1'b0;
    r0 = rdy_cnt;
    e0 = err_cnt;
    send_frame(8'h47, 1'b0, 3, -1);
    cyc(BAUD_DIV);
    @(negedge clk);
`ifdef CMD_RX_STOP_CHK_EN
    chk("bad_stop_err", 32'(err_cnt - e0), 32'(1));
    chk("bad_stop_no_rdy", 32'(rdy_cnt - r0), 32'(0));
    chk("bad_stop_data", 32'(rx_data), 32'h53);
    chk("bad_stop_pwr", 32'(pwr_up), 32'(0));
`else
    chk("bad_stop_rdy", 32'(rdy_cnt - r0), 32'(1));
    chk("bad_stop_no_err", 32'(err_cnt - e0), 32'(0));
    chk("bad_stop_data", 32'(rx_data), 32'h47);
    chk("bad_stop_pwr", 32'(pwr_up), 32'(1));
`endif
    cyc(1);

    send_frame(8'h47, 1'b1, 1, -1);
    cyc(2);
    @(negedge clk);
    chk("pre_rst_pwr", 32'(pwr_up), 32'(1));
    cyc(1);
    send_frame(8'h47, 1'b1, 1, 4);
    cyc(2 * BAUD_DIV);
    send_frame(8'h55, 1'b1, 1, -1);
    cyc(2);
    @(negedge clk);
    chk("post_rst_data", 32'(rx_data), 32'h55);
    chk("post_rst_pwr", 32'(pwr_up), 32'(0));
    cyc(1);

    ro_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int         sel;
      int         gap;
      logic [7:0] b;
      logic       sv;
      sel = $urandom_range(0, 3);
      b   = (sel == 0) ? 8'h47 : (sel == 1) ? 8'h53 : 8'($urandom);
      sv  = ($urandom_range(0, 7) != 0);
      send_frame(b, sv, 1, -1);
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(4, 2 * BAUD_DIV);
      if (!sv && gap < 4) gap = 4;
      if (gap > 0) cyc(gap);
    end
    ro_rand = 1'b0;
    rider_off = 1'b0;
    cyc(BAUD_DIV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
